dsram_like_responder: RTL and testbench

- Slave (responder) end of the CPU's sram-like data interface (req/wr/size/wstrb/addr/wdata, addr_ok/data_ok/rdata).
- Accepts requests from the pre-MEM stage and performs them on a synchronous single-port word SRAM.
- Returns in-order data_ok responses after a configurable fixed latency.
- Used as the data-side memory model in simulation and as the on-chip scratchpad responder.

---
 rtl/dsram_like_responder_pkg.sv | 28 ++
 rtl/dsram_like_responder_resp_fifo.sv | 41 ++++
 rtl/dsram_like_responder.sv | 115 +++++++++++
 tb/tb_dsram_like_responder.sv | 303 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dsram_like_responder_pkg.sv
// Shared types and constants for the sram-like data interface responder and its requesters.
package dsram_like_responder_pkg;

  typedef enum logic [1:0] {
    SIZE_BYTE = 2'd0,
    SIZE_HALF = 2'd1,
    SIZE_WORD = 2'd2
  } dsram_size_e;

  typedef struct packed {
    logic        wr;
    dsram_size_e size;
    logic [3:0]  wstrb;
    logic [31:0] addr;
    logic [31:0] wdata;
  } dsram_req_t;

  localparam int LATENCY_MIN = 1;
  localparam int LATENCY_MAX = 8;
  localparam int DEPTH_MIN   = 1;
  localparam int DEPTH_MAX   = 8;

  // A single-entry buffer still needs a one-bit pointer.
  function automatic int ptr_width(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/dsram_like_responder_resp_fifo.sv
// Circular response buffer: filled the cycle after the SRAM access, drained in order on data_ok.
module dsram_like_responder_resp_fifo
  import dsram_like_responder_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        push,
  input  logic [31:0] push_data,
  input  logic        pop,
  output logic [31:0] pop_data
);

  localparam int PTR_W = ptr_width(DEPTH);

  logic [31:0]      entry [DEPTH];
  logic [PTR_W-1:0] wptr;
  logic [PTR_W-1:0] rptr;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  always_ff @(posedge clk) begin
    if (reset) begin
      wptr <= '0;
      rptr <= '0;
    end else begin
      if (push) wptr <= ptr_inc(wptr);
      if (pop)  rptr <= ptr_inc(rptr);
    end
  end

  always_ff @(posedge clk) begin
    if (push && !reset) entry[wptr] <= push_data;
  end

  assign pop_data = entry[rptr];

endmodule

// File: rtl/dsram_like_responder.sv
// Responder end of the sram-like data interface: issues accepted requests to a synchronous
// word SRAM and answers them in order after a fixed latency.
module dsram_like_responder
  import dsram_like_responder_pkg::*;
#(
  parameter int ADDR_W  = 16,
  parameter int LATENCY = 2,
  parameter int DEPTH   = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              data_req,
  input  logic              data_wr,
  input  logic [1:0]        data_size,
  input  logic [3:0]        data_wstrb,
  input  logic [31:0]       data_addr,
  input  logic [31:0]       data_wdata,
  output logic              data_addr_ok,
  output logic              data_data_ok,
  output logic [31:0]       data_rdata,
  output logic              mem_en,
  output logic [3:0]        mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata
);

  localparam int CNT_W = $clog2(DEPTH) + 1;

  dsram_req_t         req;
  logic               accept;
  logic [CNT_W-1:0]   outstanding;
  logic [LATENCY-1:0] vld_p;
  logic [31:0]        rsp_data;
  logic [31:0]        rdata_hold;
  logic               unused_req_bits;

  assign req = '{
    wr:    data_wr,
    size:  dsram_size_e'(data_size),
    wstrb: data_wstrb,
    addr:  data_addr,
    wdata: data_wdata
  };

  // Size and the byte offset are not interpreted: alignment belongs to the requester.
  assign unused_req_bits = ^{req.size, req.addr};

  // Stage T: handshake and SRAM issue happen in the same cycle.
  assign accept       = data_req && !reset && (outstanding < CNT_W'(DEPTH));
  assign data_addr_ok = accept;
  assign mem_en       = accept;
  assign mem_we       = (accept && req.wr) ? req.wstrb : 4'h0;
  assign mem_addr     = req.addr[ADDR_W+1:2];
  assign mem_wdata    = req.wdata;

  always_ff @(posedge clk) begin
    if (reset) begin
      outstanding <= '0;
    end else begin
      case ({accept, data_data_ok})
        2'b10:   outstanding <= outstanding + 1'b1;
        2'b01:   outstanding <= outstanding - 1'b1;
        default: outstanding <= outstanding;
      endcase
    end
  end

  // Stages T+1..T+LATENCY: token shift register, the last stage is the response strobe.
  always_ff @(posedge clk) begin
    if (reset) begin
      vld_p <= '0;
    end else begin
      vld_p[0] <= accept;
      for (int i = 1; i < LATENCY; i++) vld_p[i] <= vld_p[i-1];
    end
  end

  assign data_data_ok = vld_p[LATENCY-1];

  generate
    if (LATENCY == 1) begin : g_bypass
      assign rsp_data = mem_rdata;
    end else begin : g_buf
      logic rd_p1;

      always_ff @(posedge clk) begin
        rd_p1 <= accept && !req.wr;
      end

      // Writes occupy a slot too so that responses stay aligned with tokens.
      dsram_like_responder_resp_fifo #(
        .DEPTH(DEPTH)
      ) u_resp_fifo (
        .clk      (clk),
        .reset    (reset),
        .push     (vld_p[0]),
        .push_data(rd_p1 ? mem_rdata : 32'h0),
        .pop      (data_data_ok),
        .pop_data (rsp_data)
      );
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (reset) begin
      rdata_hold <= '0;
    end else if (data_data_ok) begin
      rdata_hold <= rsp_data;
    end
  end

  assign data_rdata = data_data_ok ? rsp_data : rdata_hold;

endmodule

// File: tb/tb_dsram_like_responder.sv
// Bench for dsram_like_responder: three configurations driven against a queue-based response model.
module tb_dsram_like_responder;

  localparam int N = 3;
  localparam int LATV [N] = '{2, 6, 1};
  localparam int DEPV [N] = '{4, 2, 4};

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst       [N];
  logic        req       [N];
  logic        wr        [N];
  logic [1:0]  size      [N];
  logic [3:0]  wstrb     [N];
  logic [31:0] addr      [N];
  logic [31:0] wdata     [N];
  logic        addr_ok   [N];
  logic        data_ok   [N];
  logic [31:0] rdata     [N];
  logic        mem_en    [N];
  logic [3:0]  mem_we    [N];
  logic [15:0] mem_addr  [N];
  logic [31:0] mem_wdata [N];
  logic [31:0] mem_rdata [N];

  dsram_like_responder #(.ADDR_W(16), .LATENCY(2), .DEPTH(4)) u_l2 (
    .clk(clk), .reset(rst[0]), .data_req(req[0]), .data_wr(wr[0]), .data_size(size[0]),
    .data_wstrb(wstrb[0]), .data_addr(addr[0]), .data_wdata(wdata[0]),
    .data_addr_ok(addr_ok[0]), .data_data_ok(data_ok[0]), .data_rdata(rdata[0]),
    .mem_en(mem_en[0]), .mem_we(mem_we[0]), .mem_addr(mem_addr[0]),
    .mem_wdata(mem_wdata[0]), .mem_rdata(mem_rdata[0]));

  dsram_like_responder #(.ADDR_W(16), .LATENCY(6), .DEPTH(2)) u_l6 (
    .clk(clk), .reset(rst[1]), .data_req(req[1]), .data_wr(wr[1]), .data_size(size[1]),
    .data_wstrb(wstrb[1]), .data_addr(addr[1]), .data_wdata(wdata[1]),
    .data_addr_ok(addr_ok[1]), .data_data_ok(data_ok[1]), .data_rdata(rdata[1]),
    .mem_en(mem_en[1]), .mem_we(mem_we[1]), .mem_addr(mem_addr[1]),
    .mem_wdata(mem_wdata[1]), .mem_rdata(mem_rdata[1]));

  dsram_like_responder #(.ADDR_W(16), .LATENCY(1), .DEPTH(4)) u_l1 (
    .clk(clk), .reset(rst[2]), .data_req(req[2]), .data_wr(wr[2]), .data_size(size[2]),
    .data_wstrb(wstrb[2]), .data_addr(addr[2]), .data_wdata(wdata[2]),
    .data_addr_ok(addr_ok[2]), .data_data_ok(data_ok[2]), .data_rdata(rdata[2]),
    .mem_en(mem_en[2]), .mem_we(mem_we[2]), .mem_addr(mem_addr[2]),
    .mem_wdata(mem_wdata[2]), .mem_rdata(mem_rdata[2]));

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] d,
                                        input logic [3:0] be);
    logic [31:0] r;
    r = old;
    for (int b = 0; b < 4; b++) if (be[b]) r[b*8 +: 8] = d[b*8 +: 8];
    return r;
  endfunction

  function automatic logic [31:0] pre(input int k, input int i);
    if (k == 2 && i == 12) return 32'hCAFEF00D;
    return 32'h5A00_0000 ^ (32'(k) << 20) ^ (32'(i) * 32'h0001_0101);
  endfunction

  // Write-first synchronous SRAM, one per configuration.
  logic [31:0] smem [N][64];
  initial begin
    for (int k = 0; k < N; k++) begin
      mem_rdata[k] = 32'h0;
      for (int i = 0; i < 64; i++) smem[k][i] = pre(k, i);
    end
    forever begin
      @(posedge clk);
      for (int k = 0; k < N; k++) begin
        if (mem_en[k]) begin
          smem[k][mem_addr[k][5:0]] <= merge(smem[k][mem_addr[k][5:0]], mem_wdata[k], mem_we[k]);
          mem_rdata[k] <= merge(smem[k][mem_addr[k][5:0]], mem_wdata[k], mem_we[k]);
        end
      end
    end
  end

  int passed = 0;
  int total  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h, expected %h", name, act, exp);
  endtask

  // Reference model: outstanding responses as a queue of (due cycle, is_read, data).
  typedef struct {
    int          due;
    bit          rd;
    logic [31:0] data;
  } rsp_t;

  rsp_t        mq [N][$];
  logic [31:0] mmem [N][64];
  bit          hold_known [N];
  logic [31:0] hold_val [N];
  int          cyc;
  int          last_acc [N];
  int          last_dok [N];
  int          dut_dok_cnt [N];
  logic [31:0] mdl_rd [N];
  logic [31:0] dut_rd [N];

  initial begin
    bit          eok;
    bit          edok;
    int          w;
    logic [31:0] rv;
    rsp_t        e;
    cyc = 0;
    for (int k = 0; k < N; k++) begin
      hold_known[k] = 1'b0;
      hold_val[k] = 32'h0;
      last_acc[k] = 0;
      last_dok[k] = 0;
      dut_dok_cnt[k] = 0;
      mdl_rd[k] = 32'h0;
      dut_rd[k] = 32'h0;
      for (int i = 0; i < 64; i++) mmem[k][i] = pre(k, i);
    end
    @(posedge clk);
    forever begin
      @(negedge clk);
      for (int k = 0; k < N; k++) begin
        eok  = !rst[k] && req[k] && (mq[k].size() < DEPV[k]);
        edok = (mq[k].size() > 0) && (mq[k][0].due == cyc);
        check($sformatf("addr_ok[%0d]@%0d", k, cyc), 32'(addr_ok[k]), 32'(eok));
        check($sformatf("data_ok[%0d]@%0d", k, cyc), 32'(data_ok[k]), 32'(edok));
        check($sformatf("mem_en[%0d]@%0d", k, cyc), 32'(mem_en[k]), 32'(eok));
        if (eok) begin
          check($sformatf("mem_addr[%0d]@%0d", k, cyc), 32'(mem_addr[k]), 32'(addr[k][17:2]));
          check($sformatf("mem_we[%0d]@%0d", k, cyc), 32'(mem_we[k]), wr[k] ? 32'(wstrb[k]) : 32'h0);
          check($sformatf("mem_wdata[%0d]@%0d", k, cyc), mem_wdata[k], wdata[k]);
        end
        if (edok && mq[k][0].rd)
          check($sformatf("rdata[%0d]@%0d", k, cyc), rdata[k], mq[k][0].data);
        else if (!edok && hold_known[k])
          check($sformatf("rdata_hold[%0d]@%0d", k, cyc), rdata[k], hold_val[k]);
        if (data_ok[k]) begin
          dut_dok_cnt[k]++;
          dut_rd[k] = rdata[k];
        end
        if (rst[k]) begin
          mq[k].delete();
          hold_known[k] = 1'b1;
          hold_val[k] = 32'h0;
        end else begin
          if (edok) begin
            if (mq[k][0].rd) begin
              hold_known[k] = 1'b1;
              hold_val[k] = mq[k][0].data;
              mdl_rd[k] = mq[k][0].data;
            end else begin
              hold_known[k] = 1'b0;
            end
            last_dok[k] = cyc;
            void'(mq[k].pop_front());
          end
          if (eok) begin
            w  = int'(addr[k][7:2]);
            rv = mmem[k][w];
            if (wr[k]) mmem[k][w] = merge(rv, wdata[k], wstrb[k]);
            e.due  = cyc + LATV[k];
            e.rd   = !wr[k];
            e.data = rv;
            mq[k].push_back(e);
            last_acc[k] = cyc;
          end
        end
      end
      cyc++;
    end
  end

  task automatic wait_cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Presents one request and holds it until the handshake edge has passed.
  task automatic issue(input int k, input logic w, input logic [31:0] a, input logic [3:0] s,
                       input logic [31:0] d, input logic [1:0] sz);
    int n;
    n = 0;
    req[k] = 1'b1;
    wr[k] = w;
    addr[k] = a;
    wstrb[k] = s;
    wdata[k] = d;
    size[k] = sz;
    do begin
      @(negedge clk);
      n++;
    end while (!addr_ok[k] && n < 200);
    check($sformatf("accept_wait[%0d]", k), 32'(addr_ok[k]), 32'h1);
    @(posedge clk);
    #1;
    req[k] = 1'b0;
  endtask

  task automatic rand_stream(input int k);
    for (int n = 0; n < 120; n++) begin
      issue(k, 1'($urandom_range(0, 1)), 32'($urandom_range(0, 15)) << 2,
            4'($urandom_range(1, 15)), $urandom, 2'($urandom_range(0, 2)));
      if ($urandom_range(0, 3) == 0) wait_cycles($urandom_range(1, 3));
    end
  endtask

  initial begin
    int a0;
    int a1;
    int c1;
    for (int k = 0; k < N; k++) begin
      rst[k] = 1'b1;
      req[k] = 1'b0;
      wr[k] = 1'b0;
      size[k] = 2'd0;
      wstrb[k] = 4'h0;
      addr[k] = 32'h0;
      wdata[k] = 32'h0;
    end
    wait_cycles(2);
    for (int k = 0; k < N; k++) rst[k] = 1'b0;
    wait_cycles(1);

    // Word write then read back.
    issue(0, 1'b1, 32'h10, 4'hF, 32'hDEADBEEF, 2'd2);
    issue(0, 1'b0, 32'h10, 4'h0, 32'h0, 2'd2);
    a0 = last_acc[0];
    wait_cycles(4);
    check("t1_model_rdata", mdl_rd[0], 32'hDEADBEEF);
    check("t1_dut_rdata", dut_rd[0], 32'hDEADBEEF);
    check("t1_latency", 32'(last_dok[0] - a0), 32'd2);

    // Byte-lane merge.
    issue(0, 1'b1, 32'h20, 4'hF, 32'h12345678, 2'd2);
    issue(0, 1'b1, 32'h20, 4'h4, 32'h00AB0000, 2'd0);
    issue(0, 1'b0, 32'h20, 4'h0, 32'h0, 2'd2);
    wait_cycles(4);
    check("t2_model_rdata", mdl_rd[0], 32'h12AB5678);
    check("t2_dut_rdata", dut_rd[0], 32'h12AB5678);

    // Eight back-to-back reads across pointer wrap.
    issue(0, 1'b0, 32'h0, 4'h0, 32'h0, 2'd2);
    a0 = last_acc[0];
    for (int i = 1; i < 8; i++) issue(0, 1'b0, 32'(i) << 2, 4'h0, 32'h0, 2'd2);
    wait_cycles(4);
    check("t3_accept_span", 32'(last_acc[0] - a0), 32'd7);
    check("t3_last_latency", 32'(last_dok[0] - last_acc[0]), 32'd2);
    check("t3_last_rdata", dut_rd[0], pre(0, 7));

    // Full boundary: LATENCY 6, DEPTH 2.
    issue(1, 1'b0, 32'h0, 4'h0, 32'h0, 2'd2);
    a0 = last_acc[1];
    issue(1, 1'b0, 32'h4, 4'h0, 32'h0, 2'd2);
    a1 = last_acc[1];
    issue(1, 1'b0, 32'h8, 4'h0, 32'h0, 2'd2);
    check("t4_second_accept", 32'(a1 - a0), 32'd1);
    check("t4_refill_accept", 32'(last_acc[1] - a0), 32'd7);
    wait_cycles(8);
    check("t4_last_latency", 32'(last_dok[1] - last_acc[1]), 32'd6);
    check("t4_last_rdata", dut_rd[1], pre(1, 2));

    // LATENCY 1 bypass.
    issue(2, 1'b0, 32'h30, 4'h0, 32'h0, 2'd2);
    a0 = last_acc[2];
    wait_cycles(3);
    check("t5_model_rdata", mdl_rd[2], 32'hCAFEF00D);
    check("t5_dut_rdata", dut_rd[2], 32'hCAFEF00D);
    check("t5_latency", 32'(last_dok[2] - a0), 32'd1);

    // Reset with requests in flight.
    issue(0, 1'b0, 32'h0, 4'h0, 32'h0, 2'd2);
    issue(0, 1'b0, 32'h4, 4'h0, 32'h0, 2'd2);
    issue(0, 1'b0, 32'h8, 4'h0, 32'h0, 2'd2);
    rst[0] = 1'b1;
    req[0] = 1'b1;
    wait_cycles(1);
    rst[0] = 1'b0;
    req[0] = 1'b0;
    c1 = dut_dok_cnt[0];
    wait_cycles(8);
    check("t6_no_dok_after_reset", 32'(dut_dok_cnt[0] - c1), 32'd0);
    issue(0, 1'b0, 32'h8, 4'h0, 32'h0, 2'd2);
    a0 = last_acc[0];
    wait_cycles(4);
    check("t6_fresh_rdata", dut_rd[0], pre(0, 2));
    check("t6_fresh_latency", 32'(last_dok[0] - a0), 32'd2);

    fork
      rand_stream(0);
      rand_stream(1);
      rand_stream(2);
    join
    wait_cycles(20);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
